// File: rtl/chain_loader_pkg.sv
// chain_loader_pkg: command code, FSM state encoding and image sizing shared by the chain loader
package chain_loader_pkg;
    localparam logic [7:0] CMD_SHIFT = 8'h53;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_SEND_CMD  = 3'd2;
    localparam logic [2:0] ST_SEND_DATA = 3'd3;
    localparam logic [2:0] ST_WAIT_RESP = 3'd4;
    localparam logic [2:0] ST_FINISH    = 3'd5;
    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        FETCH     = ST_FETCH,
        SEND_CMD  = ST_SEND_CMD,
        SEND_DATA = ST_SEND_DATA,
        WAIT_RESP = ST_WAIT_RESP,
        FINISH    = ST_FINISH
    } state_t;
    function automatic int nbytes(input int bits);
        return (bits + 7) / 8;
    endfunction
endpackage

// File: rtl/chain_loader_if.sv
// chain_loader_if: ROM, UART tx/rx, readback and status signals of the chain loader
interface chain_loader_if #(parameter int AW = 8);
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          tx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rb_valid;
    logic [7:0]    rb_data;
    logic          busy;
    logic          done;
    logic          error;
    modport master (
        input  start, rom_data, tx_ready, rx_valid, rx_data,
        output rom_addr, tx_valid, tx_data, rb_valid, rb_data, busy, done, error
    );
    modport slave (
        output start, rom_data, tx_ready, rx_valid, rx_data,
        input  rom_addr, tx_valid, tx_data, rb_valid, rb_data, busy, done, error
    );
endinterface

// File: rtl/chain_loader_tx_holder.sv
// chain_loader_tx_holder: single-entry valid/ready output register, loaded by its owner, cleared on transfer
module chain_loader_tx_holder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/chain_loader.sv
// chain_loader: streams a ROM image into a BLE scan chain over UART shift commands and returns the echoed tail bytes
module chain_loader
    import chain_loader_pkg::*;
#(
    parameter int CHAIN_BITS = 32,
    parameter int AW         = 8,
    parameter int TIMEOUT    = 1000000
) (
    input logic clk,
    input logic rst,
    chain_loader_if.master bus
);
    localparam int NBYTES = nbytes(CHAIN_BITS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NBYTES - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
    state_t state, next;
    logic [CW-1:0] cnt;
    logic fire, got, last, expired;
    assign fire = bus.tx_valid & bus.tx_ready;
    assign got = state == WAIT_RESP && bus.rx_valid;
    assign last = bus.rom_addr == LAST_ADDR;
    assign expired = state == WAIT_RESP && !bus.rx_valid && cnt == LAST_CNT;
    assign bus.busy = state != IDLE;
    assign bus.done = state == FINISH;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:      next = bus.start ? FETCH : IDLE;
            FETCH:     next = SEND_CMD;
            SEND_CMD:  next = fire ? SEND_DATA : SEND_CMD;
            SEND_DATA: next = fire ? WAIT_RESP : SEND_DATA;
            WAIT_RESP: next = got ? (last ? FINISH : FETCH) : (expired ? IDLE : WAIT_RESP);
            FINISH:    next = IDLE;
            default:   next = IDLE;
        endcase
    end
    // The data byte is taken from the ROM as the command leaves; the address has been stable since FETCH.
    chain_loader_tx_holder #(.W(8)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (state == FETCH || (state == SEND_CMD && bus.tx_ready)),
        .load_data (state == FETCH ? CMD_SHIFT : bus.rom_data),
        .ready     (bus.tx_ready),
        .valid     (bus.tx_valid),
        .data      (bus.tx_data)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rom_addr <= '0;
            bus.rb_valid <= 1'b0;
            bus.rb_data  <= '0;
            bus.error    <= 1'b0;
            cnt          <= '0;
        end else begin
            bus.rb_valid <= got;
            cnt <= state == WAIT_RESP ? cnt + 1'b1 : '0;
            if (got) bus.rb_data <= bus.rx_data;
            if (state == IDLE && bus.start) begin
                bus.rom_addr <= '0;
                bus.error    <= 1'b0;
            end
            if (got && !last) bus.rom_addr <= bus.rom_addr + 1'b1;
            if (expired) bus.error <= 1'b1;
        end
    end
endmodule

// File: doc/chain_loader.md
Name: chain_loader

Overview:
- Host-side initiator for the serial configuration protocol that the on-board command decoder consumes.
- Reads a configuration image byte-by-byte from a synchronous ROM and emits UART command bytes that shift the image into a BLE scan chain.
- Collects the tail bytes the decoder echoes back and presents them as a readback stream.
- Sits between an image ROM and a UART transmitter/receiver pair on the driving board (or in a loopback test top).

Parameters:
- CHAIN_BITS, 32, scan-chain length in bits; NBYTES = ceil(CHAIN_BITS/8).
- AW, 8, ROM address width; NBYTES must be <= 2**AW.
- TIMEOUT, 1000000, max CLK cycles to wait for each response byte.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  single-cycle pulse; begins a load when idle.
- ROM_ADDR  out  AW  image byte address.
- ROM_DATA  in  8  image byte; valid exactly 1 cycle after ROM_ADDR changes.
- TX_READY  in  1  UART transmitter can accept a byte.
- TX_VALID  out  1  byte offered to UART.
- TX_DATA  out  8  byte offered to UART.
- RX_VALID  in  1  single-cycle strobe: UART received byte.
- RX_DATA  in  8  received byte.
- RB_VALID  out  1  single-cycle strobe: readback byte available.
- RB_DATA  out  8  readback byte (chain tail bits, LSB = first bit out).
- BUSY  out  1  load in progress.
- DONE  out  1  single-cycle pulse on successful completion.
- ERROR  out  1  sticky; set on response timeout, cleared by the next accepted START.

Behaviour:
- Protocol per image byte:
  - Send CMD_SHIFT (0x53), then the data byte.
  - Decoder shifts the 8 bits into the chain LSB first and returns exactly one byte of captured tail bits.
  - One command outstanding at a time.
- States: IDLE, FETCH, SEND_CMD, SEND_DATA, WAIT_RESP, FINISH.
- IDLE: BUSY=0. On START, set idx=0, ROM_ADDR=0, clear ERROR, go to FETCH.
- FETCH: one wait cycle; latch ROM_DATA into data_reg; go to SEND_CMD.
- SEND_CMD:
  - TX_VALID=1, TX_DATA=0x53.
  - Transfer completes in the cycle TX_VALID and TX_READY are both 1; then go to SEND_DATA.
- SEND_DATA:
  - TX_VALID=1, TX_DATA=data_reg.
  - On transfer, clear the timeout counter and go to WAIT_RESP.
- TX handshake rules:
  - TX_VALID never depends combinationally on TX_READY.
  - TX_DATA is stable while TX_VALID=1 and not accepted.
  - TX_VALID is registered and drops the cycle after transfer.
- WAIT_RESP:
  - On RX_VALID: RB_VALID=1 and RB_DATA=RX_DATA next cycle (registered, 1-cycle latency).
  - If idx==NBYTES-1, go to FINISH. Otherwise idx++, ROM_ADDR=idx+1, go to FETCH.
  - The counter increments every cycle. When it reaches TIMEOUT-1 with no RX_VALID, set ERROR and go to IDLE (no DONE).
- FINISH: DONE=1 for one cycle, go to IDLE.
- Last partial byte (CHAIN_BITS not a multiple of 8): the full byte is sent; the image's upper pad bits shift past the chain end. The team owns image alignment, not this block.
- START while BUSY=1 is ignored.
- RX_VALID outside WAIT_RESP is ignored (no RB_VALID).
- RX_VALID and timeout in the same cycle: the response wins; no ERROR.
- Reset values (immediately on RST, any state): IDLE, TX_VALID=0, TX_DATA=0, ROM_ADDR=0, RB_VALID=0, RB_DATA=0, BUSY=0, DONE=0, ERROR=0, counters 0.
- Reset mid-load abandons it; no DONE.
- BUSY=1 in every state except IDLE.

Decomposition:
- Shared package:
  - CMD_SHIFT=8'h53 (shared with the decoder).
  - State encoding localparams.
  - NBYTES derivation function.
- One natural sub-module: tx_holder. It is a single-entry valid/ready output register (TX_VALID/TX_DATA) that the FSM loads and that clears on transfer; it is reusable by other host-side blocks.

Test Plan:
- Nominal: CHAIN_BITS=16, ROM {0xA5,0x3C}, TX_READY=1, loopback responder returns 0x00 then 0xA5 -> TX bytes 53,A5,53,3C; RB_DATA 0x00 then 0xA5; one DONE pulse; BUSY low after; ERROR=0.
- Backpressure: TX_READY low for 5 cycles during SEND_CMD and SEND_DATA -> TX_VALID held, TX_DATA stable at 0x53/0xA5, no byte dropped or duplicated.
- Timeout: TIMEOUT=20, no response after first data byte -> ERROR=1 exactly 20 cycles after that transfer, no DONE, BUSY=0; next START clears ERROR and the load completes.
- Ignored events: START pulsed mid-load and stray RX_VALID=0xFF during SEND_CMD -> no restart, no RB_VALID, ROM_ADDR sequence 0,1 unchanged.
- Reset mid-op: assert RST during WAIT_RESP of byte 0 -> all outputs reset values immediately; fresh START re-sends from ROM_ADDR 0.
- Partial byte: CHAIN_BITS=12 -> NBYTES=2, exactly 4 TX bytes and 2 RB strobes.
